// File: rtl/tq_coef_rd.sv
// tq_coef_rd - read side of the TQ coefficient buffer.
//
// Drains a programmed run of 128-bit words from the two-port TQ RAM
// (1-cycle read latency), unpacks each word into 8 signed coefficients
// (lane 0 = bits [COEF_W-1:0] first) and streams them over valid/ready.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         pulse to begin a run (ignored while busy_o)
//   base_addr_i     first RAM word address, sampled with start_i
//   num_words_i     words in the run, 0..32 (33..63 treated as 32)
//   rd_o, raddr_o   RAM read request/address
//   rdata_i         RAM read data, valid the cycle after rd_o
//   coef_o          current coefficient
//   coef_valid_o    coef_o valid
//   coef_ready_i    consumer ready
//   coef_last_o     last coefficient of the run (with valid)
//   busy_o          run in progress
//   done_o          one-cycle pulse when the run completes
//   nz_cnt_o        (TQ_NZ_CNT_EN only) nonzero coefficients handshaken
//
// Build option: define TQ_NZ_CNT_EN to add the nonzero-coefficient counter.
module tq_coef_rd #(
    parameter int COEF_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [ADDR_W:0]     num_words_i,
    output logic                rd_o,
    output logic [ADDR_W-1:0]   raddr_o,
    input  logic [8*COEF_W-1:0] rdata_i,
    output logic [COEF_W-1:0]   coef_o,
    output logic                coef_valid_o,
    input  logic                coef_ready_i,
    output logic                coef_last_o,
    output logic                busy_o,
    output logic                done_o
`ifdef TQ_NZ_CNT_EN
    ,
    output logic [8:0]          nz_cnt_o
`endif
);

    localparam int WORD_W = 8 * COEF_W;
    localparam int NUM_W  = ADDR_W + 1;
    localparam logic [NUM_W-1:0] MAX_WORDS = NUM_W'(1 << ADDR_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t            state_q;
    logic              done_q;
    logic [ADDR_W-1:0] base_q;
    logic [NUM_W-1:0]  num_q;
    logic [NUM_W-1:0]  num_clamped;

    // Datapath registers and next states
    logic [NUM_W-1:0]  issued_q, issued_d;
    logic [NUM_W-1:0]  popped_q, popped_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        occ_q, occ_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [2:0]        lane_q, lane_d;
    logic [WORD_W-1:0] fifo_q [2];

    logic              start_acc;
    logic              credit_ok;
    logic              push, pop, hs, last_hs;
    logic [WORD_W-1:0] head;

    assign num_clamped = (num_words_i > MAX_WORDS) ? MAX_WORDS : num_words_i;
    assign start_acc   = start_i && (state_q == S_IDLE);

    // A read is only issued if the FIFO is guaranteed a free slot when the
    // data returns, so rdata_i never has to be dropped or stalled.
    assign credit_ok = (occ_q + {1'b0, inflight_q}) < 2'd2;
    assign rd_o      = (state_q == S_RUN) && (issued_q < num_q) && credit_ok;
    assign raddr_o   = base_q + issued_q[ADDR_W-1:0];   // wraps modulo RAM depth

    assign push = inflight_q;
    assign head = fifo_q[rd_ptr_q];

    // Output is a mux over registered FIFO storage: stable while stalled,
    // and the head word is visible the cycle it lands (no extra bubble).
    assign coef_valid_o = (state_q == S_RUN) && (occ_q != 2'd0);
    assign coef_o       = coef_valid_o ? head[lane_q*COEF_W +: COEF_W] : '0;
    assign coef_last_o  = coef_valid_o && (lane_q == 3'd7) &&
                          (popped_q == num_q - NUM_W'(1));

    assign hs      = coef_valid_o && coef_ready_i;
    assign pop     = hs && (lane_q == 3'd7);
    assign last_hs = hs && coef_last_o;

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;

    // Control FSM. FIN holds until done has been shown for one cycle; a run
    // ending on a handshake raises done on entry, an empty run spends one
    // extra cycle in FIN before done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            base_q  <= '0;
            num_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        base_q  <= base_addr_i;
                        num_q   <= num_clamped;
                        state_q <= (num_clamped == '0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_hs) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end
                end
                S_FIN: begin
                    if (done_q) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end else begin
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        issued_d   = issued_q + {{(NUM_W-1){1'b0}}, rd_o};
        popped_d   = popped_q + {{(NUM_W-1){1'b0}}, pop};
        inflight_d = rd_o;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        lane_d     = hs ? lane_q + 3'd1 : lane_q;
        if (start_acc) begin
            issued_d = '0;
            popped_d = '0;
            lane_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            lane_q     <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lane_q     <= lane_d;
            if (push) fifo_q[wr_ptr_q] <= rdata_i;
        end
    end

`ifdef TQ_NZ_CNT_EN
    logic [8:0] nz_q, nz_d;

    always_comb begin
        nz_d = nz_q;
        if (start_acc)                     nz_d = '0;
        else if (hs && (coef_o != '0))     nz_d = nz_q + 9'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) nz_q <= '0;
        else     nz_q <= nz_d;
    end

    assign nz_cnt_o = nz_q;
`endif

endmodule

// File: tb/tb_tq_coef_rd.sv
// Scoreboard bench for tq_coef_rd: each run pushes expected coefficients and
// read addresses into queues; a negedge monitor pops and compares on every
// handshake / read request.
module tb_tq_coef_rd;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [4:0]   base_addr_i = '0;
    logic [5:0]   num_words_i = '0;
    logic         rd_o;
    logic [4:0]   raddr_o;
    logic [127:0] rdata_i = '0;
    logic [15:0]  coef_o;
    logic         coef_valid_o;
    logic         coef_ready_i = 1'b1;
    logic         coef_last_o;
    logic         busy_o;
    logic         done_o;
`ifdef TQ_NZ_CNT_EN
    logic [8:0]   nz_cnt_o;
`endif

    tq_coef_rd dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .num_words_i  (num_words_i),
        .rd_o         (rd_o),
        .raddr_o      (raddr_o),
        .rdata_i      (rdata_i),
        .coef_o       (coef_o),
        .coef_valid_o (coef_valid_o),
        .coef_ready_i (coef_ready_i),
        .coef_last_o  (coef_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef TQ_NZ_CNT_EN
        ,
        .nz_cnt_o     (nz_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] coef;
        logic        last;
    } exp_t;

    exp_t         exp_q[$];
    logic [4:0]   addr_q[$];
    logic [127:0] mem [32];

    int nvec = 0;
    int errs = 0;
    int reads, pops, hs_cnt, last_seen, nz_exp;
    bit rnd_ready = 0;

    // RAM model: 1-cycle read latency
    always @(posedge clk) if (rd_o) rdata_i <= mem[raddr_o];

    initial forever begin
        @(posedge clk);
        #1;
        coef_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor
    logic        prev_stall = 1'b0;
    logic [15:0] prev_coef = '0;
    exp_t        e;
    logic [4:0]  a;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                nvec++;
                if (!coef_valid_o || coef_o !== prev_coef) begin
                    errs++;
                    $display("FAIL hold: valid=%0b coef=%h required valid=1 coef=%h",
                             coef_valid_o, coef_o, prev_coef);
                end
            end
            if (rd_o) begin
                nvec++;
                if (reads - pops >= 2) begin
                    errs++;
                    $display("FAIL credit: outstanding words=%0d required <2", reads - pops);
                end
                nvec++;
                if (addr_q.size() == 0) begin
                    errs++;
                    $display("FAIL raddr: unexpected read of %0d required none", raddr_o);
                end else begin
                    a = addr_q.pop_front();
                    if (raddr_o !== a) begin
                        errs++;
                        $display("FAIL raddr: got %0d required %0d", raddr_o, a);
                    end
                end
                reads++;
            end
            if (coef_valid_o && coef_ready_i) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL coef: unexpected coef %h required none", coef_o);
                end else begin
                    e = exp_q.pop_front();
                    if (coef_o !== e.coef || coef_last_o !== e.last) begin
                        errs++;
                        $display("FAIL coef: got coef=%h last=%0b required coef=%h last=%0b",
                                 coef_o, coef_last_o, e.coef, e.last);
                    end
                end
                if (coef_last_o) last_seen++;
                hs_cnt++;
                if (hs_cnt % 8 == 0) pops++;
            end
            prev_stall = coef_valid_o && !coef_ready_i;
            prev_coef  = coef_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic prep(input logic [4:0] base, input int eff);
        logic [127:0] w;
        logic [15:0]  c;
        reads = 0; pops = 0; hs_cnt = 0; last_seen = 0; nz_exp = 0;
        for (int i = 0; i < eff; i++) begin
            addr_q.push_back(5'(base + i));
            w = mem[5'(base + i)];
            for (int l = 0; l < 8; l++) begin
                c = w[l*16 +: 16];
                exp_q.push_back('{coef: c, last: (i == eff - 1 && l == 7)});
                if (c != 16'd0) nz_exp++;
            end
        end
    endtask

    // Runs one start; restart_at>0 pulses a second (to-be-ignored) start.
    task automatic run(input logic [4:0] base, input logic [5:0] num, input int restart_at);
        int eff, cyc;
        bit got;
        eff = (num > 6'd32) ? 32 : int'(num);
        prep(base, eff);
        start_i = 1'b1; base_addr_i = base; num_words_i = num;
        cyc = 0; got = 0;
        while (!got && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            start_i = 1'b0;
            if (cyc == restart_at) begin
                start_i = 1'b1; base_addr_i = 5'd10; num_words_i = 6'd7;
            end
            if (eff > 0 && cyc == 1) chk("rd_latency", 32'(rd_o), 1);
            if (eff > 0 && cyc == 2) chk("valid_early", 32'(coef_valid_o), 0);
            if (eff > 0 && cyc == 3) chk("valid_latency", 32'(coef_valid_o), 1);
            if (eff == 0) chk("empty_run_quiet", 32'(rd_o | coef_valid_o), 0);
            got = done_o;
        end
        start_i = 1'b0;
        chk("done_seen", 32'(got), 1);
        if (!rnd_ready) chk("done_latency", cyc, (eff == 0) ? 2 : 8 * eff + 3);
        chk("coef_drained", exp_q.size(), 0);
        chk("addr_drained", addr_q.size(), 0);
        chk("last_count", last_seen, (eff > 0) ? 1 : 0);
`ifdef TQ_NZ_CNT_EN
        chk("nz_cnt", 32'(nz_cnt_o), nz_exp);
`endif
        @(posedge clk);
        #1;
        chk("done_pulse", 32'({done_o, busy_o}), 0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_rd"},    32'(rd_o), 0);
        chk({name, "_raddr"}, 32'(raddr_o), 0);
        chk({name, "_coef"},  32'(coef_o), 0);
        chk({name, "_valid"}, 32'(coef_valid_o), 0);
        chk({name, "_last"},  32'(coef_last_o), 0);
        chk({name, "_busy"},  32'(busy_o), 0);
        chk({name, "_done"},  32'(done_o), 0);
`ifdef TQ_NZ_CNT_EN
        chk({name, "_nz"},    32'(nz_cnt_o), 0);
`endif
    endtask

    initial begin
        // Word a, lane l = a*256 + l, odd words negative (bit 15 set).
        // Word 0 is therefore 0x0007_0006_..._0000.
        for (int ad = 0; ad < 32; ad++)
            for (int l = 0; l < 8; l++)
                mem[ad][l*16 +: 16] = 16'(ad * 256 + l) | ((ad % 2 == 1) ? 16'h8000 : 16'h0000);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(5'd0, 6'd1, 0);          // single word, lanes 0..7
        run(5'd30, 6'd4, 0);         // address wrap 30,31,0,1
        rnd_ready = 1;
        run(5'd0, 6'd32, 0);         // full buffer under random backpressure
        rnd_ready = 0;
        @(posedge clk);
        #1;
        run(5'd7, 6'd0, 0);          // empty run
        run(5'd4, 6'd2, 5);          // start while busy is ignored
        run(5'd5, 6'd40, 0);         // oversize count clamps to 32

        // Reset mid-run: outputs clear, pending run never reports done
        prep(5'd3, 8);
        start_i = 1'b1; base_addr_i = 5'd3; num_words_i = 6'd8;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("midrun_reset");
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("no_done_after_reset", 32'({done_o, coef_valid_o, rd_o}), 0);
        end

        // Nonzero count: 3, 0xFFFF in word 20; 1, 0x8000, 2 in word 21
        mem[20] = 128'h0000_0000_0000_FFFF_0000_0000_0003_0000;
        mem[21] = 128'h0002_0000_8000_0000_0001_0000_0000_0000;
        run(5'd20, 6'd2, 0);
        chk("nz_model", nz_exp, 5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
